// File: rtl/pong_pkg.sv
// Shared definitions for the parameterised pong game.
//   state_e    : top-level game states
//   side_e     : player side encoding (LEFT=1, RIGHT=0)
//   PER_W      : width of ball-step period and step counter
//                (BASE_PERIOD must fit in PER_W bits)
//   other_side : returns the opposing player
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MOVE_R = 3'd1,
    ST_MOVE_L = 3'd2,
    ST_POINT  = 3'd3,
    ST_OVER   = 3'd4
  } state_e;

  typedef enum logic {
    SIDE_RIGHT = 1'b0,
    SIDE_LEFT  = 1'b1
  } side_e;

  localparam int PER_W = 8;

  function automatic side_e other_side(input side_e s);
    if (s == SIDE_LEFT) begin
      return SIDE_RIGHT;
    end else begin
      return SIDE_LEFT;
    end
  endfunction

endpackage

// File: rtl/pong_game_param_if.sv
// Buses of the pong game.
//   pong_game_param_if : player/display bundle (switches in, display and
//                        score out). master = player side, slave = game side.
//   pong_step_if       : step-timer bundle (load, period -> step pulse).
//                        master = game controller, slave = timer.
interface pong_game_param_if #(
  parameter int NUM_LEDS = 16,
  parameter int SCORE_W  = 4
);
  logic                left_sw;
  logic                right_sw;
  logic [NUM_LEDS-1:0] led;
  logic [SCORE_W-1:0]  score_left;
  logic [SCORE_W-1:0]  score_right;
  logic                game_over;
  logic                winner;

  modport master (output left_sw, right_sw,
                  input  led, score_left, score_right, game_over, winner);
  modport slave  (input  left_sw, right_sw,
                  output led, score_left, score_right, game_over, winner);
endinterface

interface pong_step_if;
  logic                       load;
  logic [pong_pkg::PER_W-1:0] period;
  logic                       step;

  modport master (output load, period, input step);
  modport slave  (input load, period, output step);
endinterface

// File: rtl/pong_step_timer.sv
// Ball step timer: counts clocks since the last load or step and pulses
// step for one clock when the count reaches period clocks.
//   clk_game : clock
//   rst      : synchronous active-low reset
//   tmr      : load (restart count), period (clocks per step), step (pulse)
module pong_step_timer
  import pong_pkg::*;
(
  input logic        clk_game,
  input logic        rst,
  pong_step_if.slave tmr
);

  logic [PER_W-1:0] cnt_q;
  logic [PER_W-1:0] cnt_d;

  // step fires on the period-th clock after a load
  assign tmr.step = (cnt_q == (tmr.period - PER_W'(1)));

  // counter restarts on load or when a step is issued
  always_comb begin
    cnt_d = cnt_q;
    if (tmr.load || tmr.step) begin
      cnt_d = PER_W'(0);
    end else begin
      cnt_d = cnt_q + PER_W'(1);
    end
  end

  // counter register
  always_ff @(posedge clk_game) begin
    if (!rst) begin
      cnt_q <= PER_W'(0);
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pong_game_param.sv
// One-dimensional pong on a row of NUM_LEDS LEDs.
//   clk_game, rst (sync, active-low)
//   left_sw, right_sw        : player switches, acted on at rising edges
//   led                      : playfield (ball, point flash, game-over blink)
//   score_left, score_right  : saturating scores
//   game_over, winner        : match finished, 1 = left won
// Ball position: NUM_LEDS+1 = left border, 0 = right border, k lights led[k-1].
module pong_game_param
  import pong_pkg::*;
#(
  parameter int NUM_LEDS    = 16,
  parameter int HIT_W       = 2,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9,
  parameter int BASE_PERIOD = 8,
  parameter int MIN_PERIOD  = 2
) (
  input  logic                clk_game,
  input  logic                rst,
  input  logic                left_sw,
  input  logic                right_sw,
  output logic [NUM_LEDS-1:0] led,
  output logic [SCORE_W-1:0]  score_left,
  output logic [SCORE_W-1:0]  score_right,
  output logic                game_over,
  output logic                winner
);

  localparam int                  POS_W     = $clog2(NUM_LEDS + 2);
  localparam logic [POS_W-1:0]    POS_BL    = POS_W'(NUM_LEDS + 1);
  localparam logic [POS_W-1:0]    POS_BR    = POS_W'(0);
  localparam logic [POS_W-1:0]    POS_ONE   = POS_W'(1);
  localparam logic [POS_W-1:0]    POS_N     = POS_W'(NUM_LEDS);
  localparam logic [POS_W-1:0]    POS_HIT   = POS_W'(HIT_W);
  localparam logic [POS_W-1:0]    POS_LWIN  = POS_W'(NUM_LEDS - HIT_W + 1);
  localparam logic [PER_W-1:0]    BASE_P    = PER_W'(BASE_PERIOD);
  localparam logic [PER_W-1:0]    MIN_P     = PER_W'(MIN_PERIOD);
  localparam logic [SCORE_W-1:0]  WIN_S     = SCORE_W'(WIN_SCORE);
  localparam logic [NUM_LEDS-1:0] LED_R_END = NUM_LEDS'(1);
  localparam logic [NUM_LEDS-1:0] LED_L_END = LED_R_END << (NUM_LEDS - 1);
  localparam logic [NUM_LEDS-1:0] LED_ALL   = {NUM_LEDS{1'b1}};

  // scores stop at the winning value
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    if (s < WIN_S) begin
      return s + SCORE_W'(1);
    end else begin
      return s;
    end
  endfunction

  state_e               state_q, state_d;
  side_e                server_q, server_d;
  side_e                scorer_q, scorer_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic [PER_W-1:0]     period_q, period_d;
  logic [SCORE_W-1:0]   score_l_q, score_l_d;
  logic [SCORE_W-1:0]   score_r_q, score_r_d;
  logic                 blink_q, blink_d;
  logic                 left_prev_q, left_prev_d;
  logic                 right_prev_q, right_prev_d;
  logic [NUM_LEDS-1:0]  led_q, led_d;
  logic                 game_over_q, game_over_d;
  logic                 winner_q, winner_d;

  logic                 l_press_s, r_press_s;
  logic                 award_s;
  side_e                award_side_s;
  logic                 on_field_s, right_win_s, left_win_s;
  logic                 step_s;

  pong_step_if step_bus ();

  pong_step_timer u_step_timer (
    .clk_game (clk_game),
    .rst      (rst),
    .tmr      (step_bus)
  );

  // any state change restarts the timer; only rallies use the shrinking period
  assign step_bus.load   = (state_d != state_q);
  assign step_bus.period = ((state_q == ST_MOVE_R) || (state_q == ST_MOVE_L)) ? period_q : BASE_P;
  assign step_s          = step_bus.step;

  assign l_press_s   = left_sw & ~left_prev_q;
  assign r_press_s   = right_sw & ~right_prev_q;
  assign on_field_s  = (pos_q >= POS_ONE) && (pos_q <= POS_N);
  assign right_win_s = (pos_q >= POS_ONE) && (pos_q <= POS_HIT);
  assign left_win_s  = (pos_q >= POS_LWIN) && (pos_q <= POS_N);

  // game state machine: next state, ball, period, scores
  always_comb begin
    state_d      = state_q;
    server_d     = server_q;
    scorer_d     = scorer_q;
    pos_d        = pos_q;
    period_d     = period_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    blink_d      = blink_q;
    left_prev_d  = left_sw;
    right_prev_d = right_sw;
    award_s      = 1'b0;
    award_side_s = SIDE_LEFT;

    case (state_q)
      ST_IDLE: begin
        if ((server_q == SIDE_LEFT) && l_press_s) begin
          state_d  = ST_MOVE_R;
          pos_d    = POS_BL;
          period_d = BASE_P;
        end else if ((server_q == SIDE_RIGHT) && r_press_s) begin
          state_d  = ST_MOVE_L;
          pos_d    = POS_BR;
          period_d = BASE_P;
        end else begin
          state_d = ST_IDLE;
        end
      end
      // the border step is taken before a press is honoured, so a press on
      // the arrival clock is a miss
      ST_MOVE_R: begin
        if (step_s && (pos_q == POS_BR)) begin
          award_s      = 1'b1;
          award_side_s = SIDE_LEFT;
        end else if (step_s && (pos_q == POS_ONE)) begin
          pos_d = POS_BR;
        end else if (r_press_s && right_win_s) begin
          state_d  = ST_MOVE_L;
          period_d = (period_q > MIN_P) ? (period_q - PER_W'(1)) : MIN_P;
        end else if (r_press_s && on_field_s) begin
          award_s      = 1'b1;
          award_side_s = SIDE_LEFT;
        end else if (step_s) begin
          pos_d = pos_q - POS_ONE;
        end else begin
          pos_d = pos_q;
        end
      end
      ST_MOVE_L: begin
        if (step_s && (pos_q == POS_BL)) begin
          award_s      = 1'b1;
          award_side_s = SIDE_RIGHT;
        end else if (step_s && (pos_q == POS_N)) begin
          pos_d = POS_BL;
        end else if (l_press_s && left_win_s) begin
          state_d  = ST_MOVE_R;
          period_d = (period_q > MIN_P) ? (period_q - PER_W'(1)) : MIN_P;
        end else if (l_press_s && on_field_s) begin
          award_s      = 1'b1;
          award_side_s = SIDE_RIGHT;
        end else if (step_s) begin
          pos_d = pos_q + POS_ONE;
        end else begin
          pos_d = pos_q;
        end
      end
      ST_POINT: begin
        if (step_s) begin
          if (((scorer_q == SIDE_LEFT) ? score_l_q : score_r_q) == WIN_S) begin
            state_d = ST_OVER;
            blink_d = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            server_d = other_side(scorer_q);
            pos_d    = (other_side(scorer_q) == SIDE_LEFT) ? POS_BL : POS_BR;
          end
        end else begin
          state_d = ST_POINT;
        end
      end
      ST_OVER: begin
        if (step_s) begin
          blink_d = ~blink_q;
        end else begin
          blink_d = blink_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (award_s) begin
      state_d  = ST_POINT;
      scorer_d = award_side_s;
      if (award_side_s == SIDE_LEFT) begin
        score_l_d = sat_inc(score_l_q);
      end else begin
        score_r_d = sat_inc(score_r_q);
      end
    end else begin
      scorer_d = scorer_q;
    end
  end

  // output images computed from the next state so outputs track state exactly
  always_comb begin
    led_d       = '0;
    game_over_d = (state_d == ST_OVER);
    winner_d    = (state_d == ST_OVER) && (scorer_d == SIDE_LEFT);
    case (state_d)
      ST_IDLE: begin
        led_d = (server_d == SIDE_LEFT) ? LED_L_END : LED_R_END;
      end
      ST_MOVE_R, ST_MOVE_L: begin
        if ((pos_d >= POS_ONE) && (pos_d <= POS_N)) begin
          led_d = LED_R_END << (pos_d - POS_ONE);
        end else begin
          led_d = {NUM_LEDS{1'b0}};
        end
      end
      ST_POINT: begin
        led_d = LED_ALL;
      end
      ST_OVER: begin
        led_d = blink_d ? LED_ALL : {NUM_LEDS{1'b0}};
      end
      default: begin
        led_d = {NUM_LEDS{1'b0}};
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk_game) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      server_q     <= SIDE_LEFT;
      scorer_q     <= SIDE_LEFT;
      pos_q        <= POS_BL;
      period_q     <= BASE_P;
      score_l_q    <= SCORE_W'(0);
      score_r_q    <= SCORE_W'(0);
      blink_q      <= 1'b0;
      left_prev_q  <= 1'b0;
      right_prev_q <= 1'b0;
      led_q        <= LED_L_END;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      server_q     <= server_d;
      scorer_q     <= scorer_d;
      pos_q        <= pos_d;
      period_q     <= period_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      blink_q      <= blink_d;
      left_prev_q  <= left_prev_d;
      right_prev_q <= right_prev_d;
      led_q        <= led_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
    end
  end

  assign led         = led_q;
  assign score_left  = score_l_q;
  assign score_right = score_r_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_pong_game_param.sv
// Randomised bench for pong_game_param against a rule-level game model.
module tb_pong_game_param;

  localparam int N    = 16;
  localparam int HIT  = 2;
  localparam int SW   = 4;
  localparam int WIN  = 3;
  localparam int BASE = 4;
  localparam int MINP = 2;

  localparam int PH_SERVE = 0;
  localparam int PH_RALLY = 1;
  localparam int PH_POINT = 2;
  localparam int PH_OVER  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  pong_game_param_if #(.NUM_LEDS(N), .SCORE_W(SW)) bus ();

  pong_game_param #(
    .NUM_LEDS(N), .HIT_W(HIT), .SCORE_W(SW),
    .WIN_SCORE(WIN), .BASE_PERIOD(BASE), .MIN_PERIOD(MINP)
  ) dut (
    .clk_game    (clk),
    .rst         (rst_n),
    .left_sw     (bus.left_sw),
    .right_sw    (bus.right_sw),
    .led         (bus.led),
    .score_left  (bus.score_left),
    .score_right (bus.score_right),
    .game_over   (bus.game_over),
    .winner      (bus.winner)
  );

  always #5 clk = ~clk;

  // reference model: phase, ball position/direction, clocks since last move
  int m_ph, m_srv, m_pos, m_dir, m_per, m_tick;
  int m_sl, m_sr, m_scorer, m_blink, m_lprev, m_rprev;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic m_award(input int who);
    if (who == 1) begin
      if (m_sl < WIN) m_sl++;
    end else begin
      if (m_sr < WIN) m_sr++;
    end
    m_scorer = who;
    m_ph     = PH_POINT;
    m_tick   = 0;
  endtask

  task automatic model_step(input logic l, input logic r, input logic rn);
    bit lp, rp, stepnow, rcv_press, in_win, on_field;
    int border;
    if (!rn) begin
      m_ph = PH_SERVE; m_srv = 1; m_pos = N + 1; m_dir = -1; m_per = BASE; m_tick = 0;
      m_sl = 0; m_sr = 0; m_scorer = 1; m_blink = 0; m_lprev = 0; m_rprev = 0;
      return;
    end
    lp = l && (m_lprev == 0);
    rp = r && (m_rprev == 0);
    m_lprev = int'(l);
    m_rprev = int'(r);
    case (m_ph)
      PH_SERVE: begin
        if (m_srv == 1 && lp) begin
          m_ph = PH_RALLY; m_dir = -1; m_pos = N + 1; m_per = BASE; m_tick = 0;
        end else if (m_srv == 0 && rp) begin
          m_ph = PH_RALLY; m_dir = 1; m_pos = 0; m_per = BASE; m_tick = 0;
        end
      end
      PH_RALLY: begin
        stepnow = (m_tick + 1 == m_per);
        if (m_dir < 0) begin
          border = 0; rcv_press = rp; in_win = (m_pos >= 1 && m_pos <= HIT);
        end else begin
          border = N + 1; rcv_press = lp; in_win = (m_pos >= N - HIT + 1 && m_pos <= N);
        end
        on_field = (m_pos >= 1 && m_pos <= N);
        if (stepnow && m_pos == border) m_award(m_dir < 0 ? 1 : 0);
        else if (stepnow && m_pos + m_dir == border) begin
          m_pos = m_pos + m_dir; m_tick = 0;
        end else if (rcv_press && in_win) begin
          m_dir = -m_dir; m_per = (m_per - 1 > MINP) ? m_per - 1 : MINP; m_tick = 0;
        end else if (rcv_press && on_field) m_award(m_dir < 0 ? 1 : 0);
        else if (stepnow) begin
          m_pos = m_pos + m_dir; m_tick = 0;
        end else m_tick++;
      end
      PH_POINT: begin
        if (m_tick + 1 == BASE) begin
          m_tick = 0;
          if (((m_scorer == 1) ? m_sl : m_sr) == WIN) begin
            m_ph = PH_OVER; m_blink = 1;
          end else begin
            m_ph = PH_SERVE; m_srv = 1 - m_scorer; m_pos = (m_srv == 1) ? N + 1 : 0;
          end
        end else m_tick++;
      end
      default: begin
        if (m_tick + 1 == BASE) begin
          m_blink = 1 - m_blink; m_tick = 0;
        end else m_tick++;
      end
    endcase
  endtask

  task automatic compare_all();
    logic [31:0] e_led;
    case (m_ph)
      PH_SERVE: e_led = (m_srv == 1) ? 32'h0000_8000 : 32'h0000_0001;
      PH_RALLY: e_led = (m_pos >= 1 && m_pos <= N) ? (32'd1 << (m_pos - 1)) : 32'd0;
      PH_POINT: e_led = 32'h0000_FFFF;
      default:  e_led = (m_blink == 1) ? 32'h0000_FFFF : 32'd0;
    endcase
    check_eq("led", {16'd0, bus.led}, e_led);
    check_eq("score_left", {28'd0, bus.score_left}, m_sl);
    check_eq("score_right", {28'd0, bus.score_right}, m_sr);
    check_eq("game_over", {31'd0, bus.game_over}, (m_ph == PH_OVER) ? 32'd1 : 32'd0);
    check_eq("winner", {31'd0, bus.winner}, (m_ph == PH_OVER && m_scorer == 1) ? 32'd1 : 32'd0);
  endtask

  task automatic cycle(input logic l, input logic r, input logic rn);
    bus.left_sw  = l;
    bus.right_sw = r;
    rst_n        = rn;
    @(posedge clk);
    #1;
    model_step(l, r, rn);
    compare_all();
  endtask

  initial begin
    int hit;
    int mode;
    int over_cnt;
    logic nl, nr, nrn, want_l, want_r;
    bus.left_sw  = 1'b0;
    bus.right_sw = 1'b0;

    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check_eq("reset_led", {16'd0, bus.led}, 32'h0000_8000);
    check_eq("reset_score_l", {28'd0, bus.score_left}, 32'd0);
    check_eq("reset_score_r", {28'd0, bus.score_right}, 32'd0);
    check_eq("reset_game_over", {31'd0, bus.game_over}, 32'd0);
    check_eq("reset_winner", {31'd0, bus.winner}, 32'd0);

    // unanswered left serve: point lands 72 clocks after the press edge
    cycle(1'b1, 1'b0, 1'b1);
    hit = 0;
    for (int k = 1; k <= 100; k++) begin
      cycle(1'b0, 1'b0, 1'b1);
      if (hit == 0 && bus.score_left == 4'd1) hit = k;
    end
    check_eq("serve_to_point_clocks", hit, 32'd72);
    check_eq("right_serves_led", {16'd0, bus.led}, 32'h0000_0001);

    mode = 1;
    over_cnt = 0;
    for (int i = 0; i < 14000; i++) begin
      nrn = 1'b1;
      over_cnt = (m_ph == PH_OVER) ? over_cnt + 1 : 0;
      if (over_cnt > 30 || $urandom_range(0, 1499) == 0) begin
        nrn = 1'b0;
        mode = $urandom_range(0, 3);
      end
      want_l = 1'b0;
      want_r = 1'b0;
      case (mode)
        0: begin
          nl = bus.left_sw ^ ($urandom_range(0, 5) == 0);
          nr = bus.right_sw ^ ($urandom_range(0, 5) == 0);
        end
        3: begin
          nl = 1'b1;
          nr = bus.right_sw ^ ($urandom_range(0, 4) == 0);
        end
        default: begin
          if (m_ph == PH_SERVE) begin
            want_l = (m_srv == 1) && ($urandom_range(0, 3) == 0);
            want_r = (m_srv == 0) && ($urandom_range(0, 3) == 0);
          end else if (m_ph == PH_RALLY) begin
            if (m_dir < 0 && m_pos >= 1 && m_pos <= HIT) want_r = ($urandom_range(0, 2) == 0);
            if (m_dir > 0 && m_pos >= N - HIT + 1 && m_pos <= N) want_l = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 19) == 0) want_l = 1'b1;
            if ($urandom_range(0, 39) == 0) want_r = 1'b1;
          end else begin
            want_l = ($urandom_range(0, 3) == 0);
            want_r = ($urandom_range(0, 3) == 0);
          end
          nl = want_l && !bus.left_sw;
          nr = want_r && !bus.right_sw;
        end
      endcase
      cycle(nl, nr, nrn);
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
